// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin APB master: one transfer at a time, registered APB
// controls, and an abort when the slave holds PREADY low for TIMEOUT ACCESS cycles.
module apb_req_arbiter #(
   parameter int TIMEOUT = 15
) (
   input  logic       PCLK,
   input  logic       PRESET,
   input  logic       req0,
   input  logic       req1,
   input  logic       wr0,
   input  logic       wr1,
   input  logic [6:0] addr0,
   input  logic [6:0] addr1,
   input  logic [7:0] wdata0,
   input  logic [7:0] wdata1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       done0,
   output logic       done1,
   output logic [7:0] rdata,
   output logic       err,
   output logic       PSELECT1,
   output logic       PSELECT2,
   output logic       PENABLE,
   output logic       PWRITE,
   output logic [6:0] PADDR,
   output logic [7:0] PWDATA,
   input  logic [7:0] PRDATA,
   input  logic       PREADY,
   input  logic       PSLVERR
);

   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   state_t     state_r, state_s;
   logic [7:0] cnt_r, cnt_s, cnt_inc_s;
   logic       last_r, last_s;
   logic       owner_r, owner_s;
   logic       winner_s, end_s;
   logic       gnt0_s, gnt1_s, done0_s, done1_s, err_s;
   logic       psel1_s, psel2_s, penable_s, pwrite_s;
   logic [6:0] paddr_s;
   logic [7:0] pwdata_s, rdata_s;

   // last_r names the requester granted most recently; a tie goes to the other one.
   assign winner_s  = (req0 && req1) ? ~last_r : req1;
   assign cnt_inc_s = cnt_r + 8'd1;

   // Next-state and next-output computation.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      last_s    = last_r;
      owner_s   = owner_r;
      gnt0_s    = gnt0;
      gnt1_s    = gnt1;
      done0_s   = 1'b0;
      done1_s   = 1'b0;
      err_s     = err;
      rdata_s   = rdata;
      psel1_s   = PSELECT1;
      psel2_s   = PSELECT2;
      penable_s = PENABLE;
      pwrite_s  = PWRITE;
      paddr_s   = PADDR;
      pwdata_s  = PWDATA;
      end_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (req0 || req1) begin
               state_s   = SETUP;
               owner_s   = winner_s;
               last_s    = winner_s;
               gnt0_s    = ~winner_s;
               gnt1_s    = winner_s;
               pwrite_s  = winner_s ? wr1 : wr0;
               paddr_s   = winner_s ? addr1 : addr0;
               pwdata_s  = winner_s ? wdata1 : wdata0;
               psel1_s   = winner_s ? addr1[6] : addr0[6];
               psel2_s   = winner_s ? ~addr1[6] : ~addr0[6];
               penable_s = 1'b0;
            end else begin
               gnt0_s    = 1'b0;
               gnt1_s    = 1'b0;
               psel1_s   = 1'b0;
               psel2_s   = 1'b0;
               penable_s = 1'b0;
            end
         end
         SETUP: begin
            state_s   = ACCESS;
            penable_s = 1'b1;
            cnt_s     = 8'd0;
         end
         ACCESS: begin
            if (PREADY) begin
               end_s   = 1'b1;
               err_s   = PSLVERR;
               rdata_s = PWRITE ? rdata : PRDATA;
            end else if (cnt_inc_s == TMO) begin
               end_s = 1'b1;
               err_s = 1'b1;
               cnt_s = cnt_inc_s;
            end else begin
               cnt_s = cnt_inc_s;
            end
         end
         default: begin
            state_s   = IDLE;
            gnt0_s    = 1'b0;
            gnt1_s    = 1'b0;
            psel1_s   = 1'b0;
            psel2_s   = 1'b0;
            penable_s = 1'b0;
         end
      endcase
      // Completion (normal or aborted) releases the bus and pulses the owner's done.
      if (end_s) begin
         state_s   = IDLE;
         gnt0_s    = 1'b0;
         gnt1_s    = 1'b0;
         psel1_s   = 1'b0;
         psel2_s   = 1'b0;
         penable_s = 1'b0;
         done0_s   = ~owner_r;
         done1_s   = owner_r;
      end else begin
         done0_s   = 1'b0;
         done1_s   = 1'b0;
      end
   end

   // State and output registers; reset leaves the pointer favouring req0.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_r  <= IDLE;
         cnt_r    <= 8'd0;
         last_r   <= 1'b1;
         owner_r  <= 1'b0;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         err      <= 1'b0;
         rdata    <= 8'd0;
         PSELECT1 <= 1'b0;
         PSELECT2 <= 1'b0;
         PENABLE  <= 1'b0;
         PWRITE   <= 1'b0;
         PADDR    <= 7'd0;
         PWDATA   <= 8'd0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         last_r   <= last_s;
         owner_r  <= owner_s;
         gnt0     <= gnt0_s;
         gnt1     <= gnt1_s;
         done0    <= done0_s;
         done1    <= done1_s;
         err      <= err_s;
         rdata    <= rdata_s;
         PSELECT1 <= psel1_s;
         PSELECT2 <= psel2_s;
         PENABLE  <= penable_s;
         PWRITE   <= pwrite_s;
         PADDR    <= paddr_s;
         PWDATA   <= pwdata_s;
      end
   end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter: expected transfers are queued when requested
// and checked at their SETUP cycle and at their done pulse.
module tb_apb_req_arbiter;

   localparam int TMO = 15;

   logic       PCLK, PRESET;
   logic       req0, req1, wr0, wr1;
   logic [6:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic       gnt0, gnt1, done0, done1, err;
   logic [7:0] rdata;
   logic       PSELECT1, PSELECT2, PENABLE, PWRITE;
   logic [6:0] PADDR;
   logic [7:0] PWDATA, PRDATA;
   logic       PREADY, PSLVERR;

   typedef struct {
      int         id;
      logic       wr;
      logic [6:0] addr;
      logic [7:0] wdata;
      int         pen;
      logic       err;
      logic [7:0] rdata;
   } exp_t;

   exp_t       sb_q[$];
   int         n_cmp = 0;
   int         n_err = 0;
   int         pen_cnt = 0;
   int         wait_cfg = 0;
   logic [7:0] prdata_cfg = 8'h00;
   logic       slverr_cfg = 1'b0;
   logic [7:0] model_rdata = 8'h00;

   apb_req_arbiter #(.TIMEOUT(TMO)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .rdata(rdata), .err(err),
      .PSELECT1(PSELECT1), .PSELECT2(PSELECT2), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Slave: PREADY rises after wait_cfg low ACCESS cycles; wait_cfg < 0 never answers.
   initial begin
      int acc_cnt;
      acc_cnt = 0;
      PREADY = 1'b0; PRDATA = 8'h00; PSLVERR = 1'b0;
      forever begin
         @(negedge PCLK);
         if ((PSELECT1 || PSELECT2) && PENABLE) begin
            acc_cnt++;
            PREADY  = (wait_cfg >= 0) && (acc_cnt > wait_cfg);
            PRDATA  = prdata_cfg;
            PSLVERR = slverr_cfg;
         end else begin
            acc_cnt = 0;
            PREADY  = 1'b0;
         end
      end
   end

   // Monitor: compares SETUP fields against the queue head and pops on done.
   initial begin
      exp_t e;
      forever begin
         @(negedge PCLK);
         if (!PRESET) begin
            if ((PSELECT1 || PSELECT2) && !PENABLE) begin
               if (sb_q.size() == 0) begin
                  check_eq("unexpected_setup", 32'd1, 32'd0);
               end else begin
                  e = sb_q[0];
                  check_eq("setup_gnt", {30'd0, gnt0, gnt1}, (e.id == 0) ? 32'd2 : 32'd1);
                  check_eq("setup_psel", {30'd0, PSELECT1, PSELECT2}, {30'd0, e.addr[6], ~e.addr[6]});
                  check_eq("setup_paddr", {25'd0, PADDR}, {25'd0, e.addr});
                  check_eq("setup_pwdata", {24'd0, PWDATA}, {24'd0, e.wdata});
                  check_eq("setup_pwrite", {31'd0, PWRITE}, {31'd0, e.wr});
               end
            end
            if (PENABLE) pen_cnt++;
            if (done0 || done1) begin
               if (sb_q.size() == 0) begin
                  check_eq("unexpected_done", 32'd1, 32'd0);
               end else begin
                  e = sb_q.pop_front();
                  check_eq("done_which", {30'd0, done0, done1}, (e.id == 0) ? 32'd2 : 32'd1);
                  check_eq("done_err", {31'd0, err}, {31'd0, e.err});
                  check_eq("done_rdata", {24'd0, rdata}, {24'd0, e.rdata});
                  check_eq("access_cycles", pen_cnt, e.pen);
               end
               pen_cnt = 0;
            end
         end
      end
   end

   task automatic push_exp(input int win, input bit wr, input logic [6:0] a,
                           input logic [7:0] wd, input int waitc, input logic [7:0] prd,
                           input bit slv, output int pen);
      exp_t e;
      bit   abort;
      abort   = (waitc < 0) || (waitc >= TMO);
      e.id    = win;
      e.wr    = wr;
      e.addr  = a;
      e.wdata = wd;
      e.pen   = abort ? TMO : waitc + 1;
      e.err   = abort ? 1'b1 : slv;
      if (!abort && !wr) model_rdata = prd;
      e.rdata = model_rdata;
      pen     = e.pen;
      sb_q.push_back(e);
   endtask

   task automatic wait_done(output int lat);
      lat = 1;
      forever begin
         @(negedge PCLK);
         if (done0 || done1) break;
         if (lat >= 100) begin
            check_eq("done_timeout", 32'd0, 32'd1);
            break;
         end
         @(posedge PCLK);
         lat++;
      end
   endtask

   task automatic do_xfer(input bit r0, input bit r1, input int win, input bit wr,
                          input logic [6:0] a, input logic [7:0] wd, input int waitc,
                          input logic [7:0] prd, input bit slv);
      int pen, lat;
      push_exp(win, wr, a, wd, waitc, prd, slv, pen);
      wait_cfg = waitc; prdata_cfg = prd; slverr_cfg = slv;
      if (win == 0) begin
         wr0 = wr;  addr0 = a;  wdata0 = wd;
         wr1 = ~wr; addr1 = ~a; wdata1 = ~wd;
      end else begin
         wr1 = wr;  addr1 = a;  wdata1 = wd;
         wr0 = ~wr; addr0 = ~a; wdata0 = ~wd;
      end
      @(negedge PCLK);
      req0 = r0; req1 = r1;
      @(posedge PCLK);
      #1;
      req0 = 1'b0; req1 = 1'b0;
      wait_done(lat);
      check_eq("latency", lat, 2 + pen);
   endtask

   task automatic check_zero_outputs(input string tag);
      check_eq({tag, "_ctl"}, {23'd0, gnt0, gnt1, done0, done1, PSELECT1, PSELECT2,
                               PENABLE, PWRITE, err}, 32'd0);
      check_eq({tag, "_paddr"}, {25'd0, PADDR}, 32'd0);
      check_eq({tag, "_pwdata"}, {24'd0, PWDATA}, 32'd0);
      check_eq({tag, "_rdata"}, {24'd0, rdata}, 32'd0);
   endtask

   task automatic apply_reset();
      @(negedge PCLK);
      PRESET = 1'b1;
      @(posedge PCLK);
      #1;
      PRESET = 1'b0;
      sb_q.delete();
      pen_cnt = 0;
      model_rdata = 8'h00;
      check_zero_outputs("reset");
   endtask

   initial begin
      int pen, lat, seen;
      PRESET = 1'b1;
      req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
      addr0 = 7'd0; addr1 = 7'd0; wdata0 = 8'd0; wdata1 = 8'd0;
      repeat (3) @(posedge PCLK);
      apply_reset();

      do_xfer(1'b1, 1'b0, 0, 1'b1, 7'h45, 8'hA5, 0,  8'h00, 1'b0);
      do_xfer(1'b0, 1'b1, 1, 1'b0, 7'h12, 8'h00, 3,  8'h3C, 1'b0);
      do_xfer(1'b1, 1'b0, 0, 1'b0, 7'h50, 8'h00, 1,  8'h77, 1'b1);
      do_xfer(1'b0, 1'b1, 1, 1'b1, 7'h0F, 8'h9C, 0,  8'h00, 1'b0);
      do_xfer(1'b1, 1'b0, 0, 1'b0, 7'h60, 8'h00, -1, 8'hEE, 1'b0);
      do_xfer(1'b0, 1'b1, 1, 1'b0, 7'h7E, 8'h00, TMO - 1, 8'hE1, 1'b0);
      do_xfer(1'b1, 1'b0, 0, 1'b0, 7'h21, 8'h00, TMO, 8'hD4, 1'b0);
      do_xfer(1'b1, 1'b1, 1, 1'b1, 7'h4A, 8'h5B, 2,  8'h00, 1'b0);
      do_xfer(1'b1, 1'b1, 0, 1'b0, 7'h33, 8'h00, 0,  8'hC7, 1'b0);

      // Both requesters held: grants must alternate 0,1,0,1 from reset.
      apply_reset();
      wait_cfg = 0; prdata_cfg = 8'h5A; slverr_cfg = 1'b0;
      wr0 = 1'b1; addr0 = 7'h41; wdata0 = 8'h11;
      wr1 = 1'b0; addr1 = 7'h22; wdata1 = 8'h99;
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) push_exp(0, 1'b1, 7'h41, 8'h11, 0, 8'h5A, 1'b0, pen);
         else            push_exp(1, 1'b0, 7'h22, 8'h99, 0, 8'h5A, 1'b0, pen);
      end
      @(negedge PCLK);
      req0 = 1'b1; req1 = 1'b1;
      seen = 0;
      for (int c = 0; c < 100 && seen < 4; c++) begin
         @(negedge PCLK);
         if (done0 || done1) seen++;
      end
      req0 = 1'b0; req1 = 1'b0;
      check_eq("rr_done_count", seen, 32'd4);

      // Reset in the middle of ACCESS drops the transfer without a done pulse.
      push_exp(1, 1'b1, 7'h6C, 8'h3E, -1, 8'h00, 1'b0, pen);
      wait_cfg = -1;
      wr1 = 1'b1; addr1 = 7'h6C; wdata1 = 8'h3E;
      @(negedge PCLK);
      req1 = 1'b1;
      @(posedge PCLK);
      #1;
      req1 = 1'b0;
      lat = 0;
      while (!PENABLE && lat < 10) begin
         @(negedge PCLK);
         lat++;
      end
      check_eq("reached_access", {31'd0, PENABLE}, 32'd1);
      repeat (3) @(posedge PCLK);
      apply_reset();
      repeat (4) @(negedge PCLK);
      check_eq("no_done_after_reset", {30'd0, done0, done1}, 32'd0);
      do_xfer(1'b1, 1'b1, 0, 1'b0, 7'h0A, 8'h00, 1, 8'hB2, 1'b0);

      repeat (3) @(negedge PCLK);
      check_eq("queue_empty", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: consecutive ACCESS cycles with PREADY low before abort; legal range 1..255.
REQ-002 PCLK  input  1  bus clock; all logic on rising edge.
REQ-003 PRESET  input  1  reset, synchronous, active-high.
REQ-004 req0, req1  input  1 each  transfer request from requester 0 / 1.
REQ-005 wr0, wr1  input  1 each  1=write, 0=read.
REQ-006 addr0, addr1  input  7 each  target address; bit 6 selects slave.
REQ-007 wdata0, wdata1  input  8 each  write data.
REQ-008 gnt0, gnt1  output  1 each  requester owns the bus.
REQ-009 done0, done1  output  1 each  one-cycle completion pulse.
REQ-010 rdata  output  8  read data of last completed read.
REQ-011 err  output  1  status of last completed transfer; 1=slave error or timeout.
REQ-012 PSELECT1, PSELECT2, PENABLE, PWRITE  output  1 each  APB controls.
REQ-013 PADDR  output  7; PWDATA  output  8  APB address / write data.
REQ-014 PRDATA  input  8; PREADY  input  1; PSLVERR  input  1  APB slave response.

Function
REQ-015 All outputs SHALL be registered; FSM states IDLE, SETUP, ACCESS.
REQ-016 IDLE: PSELECT1/2, PENABLE, gnt0/1 low; if req0 or req1 high at an edge, go SETUP.
REQ-017 Arbitration SHALL be round-robin: single requester wins; if both request, winner is the one not granted last; pointer updates on each grant.
REQ-018 On grant, latch winner's wr, addr, wdata into PWRITE, PADDR, PWDATA; these SHALL remain stable through ACCESS.
REQ-019 SETUP (exactly one cycle): gnt of winner high; PSELECT1=PADDR[6], PSELECT2=~PADDR[6]; PENABLE low; next state ACCESS.
REQ-020 ACCESS: PENABLE high, PSELx and gnt held; wait while PREADY low.
REQ-021 ACCESS with PREADY high at edge: next cycle state IDLE, PSELx/PENABLE/gnt low, winner's done high one cycle, err=PSLVERR; if read, rdata=PRDATA, else rdata unchanged.
REQ-022 Minimum latency: request sampled at edge k -> SETUP cycle k+1, ACCESS k+2, done in cycle k+3 for zero-wait slave.
REQ-023 Wait counter (8-bit) SHALL clear on entering ACCESS and increment each ACCESS cycle with PREADY low.
REQ-024 Counter reaching TIMEOUT with PREADY still low SHALL abort: next cycle IDLE, done pulse for winner, err=1, rdata unchanged.
REQ-025 PREADY high on the same cycle the counter reaches TIMEOUT SHALL complete normally (REQ-021), not abort.
REQ-026 Requester dropping req mid-transfer SHALL be ignored; transfer completes and done still pulses.
REQ-027 At least one IDLE cycle SHALL separate consecutive transfers; pending request re-arbitrated there.
REQ-028 rdata and err SHALL hold until the next completion.
REQ-029 At most one of gnt0/gnt1, done0/done1, PSELECT1/PSELECT2 SHALL be high in any cycle.

Reset
REQ-030 PRESET high at an edge SHALL next cycle force state IDLE, all outputs 0 (PADDR, PWDATA, rdata included), counter 0, pointer favouring req0.
REQ-031 Reset during SETUP or ACCESS SHALL drop the transfer with no done pulse.
REQ-032 PRESET SHALL take priority over all other inputs on the same edge.

Verification
REQ-033 req0=1, wr0=1, addr0=7'h45, wdata0=8'hA5, PREADY=1 -> SETUP with PSELECT1=1, PADDR=7'h45, PWDATA=8'hA5, PWRITE=1; ACCESS PENABLE=1; done0 pulse 3 cycles after request, err=0.
REQ-034 req1=1, wr1=0, addr1=7'h12, PREADY low 3 ACCESS cycles then high with PRDATA=8'h3C -> PSELECT2=1, done1 pulse, rdata=8'h3C.
REQ-035 req0 and req1 held high, continuous zero-wait slave -> grants alternate 0,1,0,1; first grant to req0 after reset.
REQ-036 TIMEOUT=15, PREADY held low -> abort after 15 ACCESS cycles, done pulse with err=1, rdata unchanged; PSLVERR=1 on completion -> err=1.
REQ-037 PRESET asserted in ACCESS -> next cycle all outputs 0, no done pulse; new request afterwards granted to req0.
